// File: rtl/layer_train_sequencer_pkg.sv
// layer_train_sequencer_pkg: shared types for the layer training sequencer
package layer_train_sequencer_pkg;
    typedef logic [7:0] zero2one_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETTLE,
        ST_LEARN,
        ST_DONE
    } train_state_t;
endpackage

// File: rtl/layer_train_sequencer_counter.sv
// train_counter: nested sample/epoch counter with last-sample/last-epoch flags
module train_counter #(
    parameter int SW = 16,
    parameter int EW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [SW-1:0] num_samples,
    input  logic [EW-1:0] num_epochs,
    output logic [SW-1:0] sample_idx,
    output logic [EW-1:0] epoch_idx,
    output logic          last_sample,
    output logic          last_epoch
);
    logic [SW-1:0] ns_q;
    logic [EW-1:0] ne_q;

    assign last_sample = sample_idx == ns_q - SW'(1);
    assign last_epoch  = epoch_idx == ne_q - EW'(1);

    // latch the run size at start, then step the nested indices once per learn;
    // the final sample of the final epoch leaves the indices parked on their last values
    always_ff @(posedge clock) begin
        if (reset) begin
            ns_q       <= '0;
            ne_q       <= '0;
            sample_idx <= '0;
            epoch_idx  <= '0;
        end else if (load) begin
            ns_q       <= num_samples;
            ne_q       <= num_epochs;
            sample_idx <= '0;
            epoch_idx  <= '0;
        end else if (advance && !(last_sample && last_epoch)) begin
            sample_idx <= last_sample ? '0 : sample_idx + SW'(1);
            epoch_idx  <= last_sample ? epoch_idx + EW'(1) : epoch_idx;
        end
    end
endmodule

// File: rtl/layer_train_sequencer.sv
// layer_train_sequencer: streams samples into a neuron_learn layer with settle/learn timing
module layer_train_sequencer
    import layer_train_sequencer_pkg::*;
#(
    parameter int N             = 16,
    parameter int M             = 43,
    parameter int SETTLE_CYCLES = 2,
    parameter int SW            = 16,
    parameter int EW            = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                learn_en,
    input  logic [SW-1:0]       num_samples,
    input  logic [EW-1:0]       num_epochs,
    input  logic                s_valid,
    output logic                s_ready,
    input  zero2one_t [N-1:0]   s_in,
    input  zero2one_t [M-1:0]   s_expected,
    output logic                valid,
    output logic                learn,
    output zero2one_t [N-1:0]   in,
    output zero2one_t [M-1:0]   expected_out,
    output logic                busy,
    output logic                done,
    output logic [SW-1:0]       sample_idx,
    output logic [EW-1:0]       epoch_idx
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    train_state_t  state;
    logic [CW-1:0] settle_cnt;
    logic          learn_en_q;
    logic          last_sample;
    logic          last_epoch;
    logic          load;
    logic          advance;
    logic          zero_run;

    assign load     = state == ST_IDLE && start && !abort;
    assign advance  = state == ST_LEARN && !abort;
    assign zero_run = num_samples == '0 || num_epochs == '0;

    train_counter #(.SW(SW), .EW(EW)) u_counter (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .num_samples (num_samples),
        .num_epochs  (num_epochs),
        .sample_idx  (sample_idx),
        .epoch_idx   (epoch_idx),
        .last_sample (last_sample),
        .last_epoch  (last_epoch)
    );

    // run-control FSM; every layer-facing and status output is registered here
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            state        <= ST_IDLE;
            valid        <= 1'b0;
            learn        <= 1'b0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            in           <= '0;
            expected_out <= '0;
            settle_cnt   <= '0;
            learn_en_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        learn_en_q <= learn_en;
                        busy       <= 1'b1;
                        state      <= zero_run ? ST_DONE : ST_FETCH;
                        done       <= zero_run;
                        s_ready    <= !zero_run;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        in           <= s_in;
                        expected_out <= s_expected;
                        s_ready      <= 1'b0;
                        valid        <= 1'b1;
                        settle_cnt   <= CW'(SETTLE_CYCLES - 1);
                        state        <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        learn <= learn_en_q;
                        state <= ST_LEARN;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                ST_LEARN: begin
                    learn   <= 1'b0;
                    valid   <= 1'b0;
                    done    <= last_sample && last_epoch;
                    s_ready <= !(last_sample && last_epoch);
                    state   <= (last_sample && last_epoch) ? ST_DONE : ST_FETCH;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_train_sequencer.sv
// tb_layer_train_sequencer: randomized run sequencing checked against an event-count model
module tb_layer_train_sequencer;
    import layer_train_sequencer_pkg::*;

    localparam int N  = 16;
    localparam int M  = 43;
    localparam int S  = 2;
    localparam int SW = 16;
    localparam int EW = 8;

    logic              clock = 1'b0;
    logic              reset, start, abort, learn_en, s_valid;
    logic [SW-1:0]     num_samples;
    logic [EW-1:0]     num_epochs;
    zero2one_t [N-1:0] s_in;
    zero2one_t [M-1:0] s_expected;
    logic              s_ready, valid, learn, busy, done;
    zero2one_t [N-1:0] in;
    zero2one_t [M-1:0] expected_out;
    logic [SW-1:0]     sample_idx;
    logic [EW-1:0]     epoch_idx;

    layer_train_sequencer #(.N(N), .M(M), .SETTLE_CYCLES(S), .SW(SW), .EW(EW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .learn_en     (learn_en),
        .num_samples  (num_samples),
        .num_epochs   (num_epochs),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_in         (s_in),
        .s_expected   (s_expected),
        .valid        (valid),
        .learn        (learn),
        .in           (in),
        .expected_out (expected_out),
        .busy         (busy),
        .done         (done),
        .sample_idx   (sample_idx),
        .epoch_idx    (epoch_idx)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // reference model: counts of accepted beats and completed learns, plus event times
    int e = 0;
    bit act = 0;
    int acc = 0, lrn = 0, tot = 0, ns_q = 0, idx_lin = 0;
    int a_last = -100, done_e = -100;
    bit len_q = 0;
    zero2one_t [N-1:0] in_x = '0;
    zero2one_t [M-1:0] exp_x = '0;
    int learn_cnt = 0, done_cnt = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, want);
        end
    endtask

    task automatic model_edge();
        e++;
        if (reset) begin
            act = 0; acc = 0; lrn = 0; idx_lin = 0; ns_q = 0; done_e = -100;
            in_x = '0; exp_x = '0;
        end else if (abort) begin
            act = 0; acc = 0; lrn = 0; done_e = -100;
            in_x = '0; exp_x = '0;
        end else if (!act) begin
            if (done_e != e - 1 && start) begin
                ns_q = int'(num_samples);
                tot = int'(num_samples) * int'(num_epochs);
                len_q = learn_en;
                idx_lin = 0; acc = 0; lrn = 0;
                if (tot == 0) done_e = e;
                else act = 1;
            end
        end else if (acc == lrn) begin
            if (s_valid) begin
                acc++; a_last = e; in_x = s_in; exp_x = s_expected;
            end
        end else if (e == a_last + S + 1) begin
            lrn++;
            if (lrn == tot) begin
                act = 0; done_e = e;
            end else idx_lin = lrn;
        end
    endtask

    task automatic compare();
        bit v;
        v = act && acc > lrn;
        check("s_ready", 512'(s_ready), 512'(act && acc == lrn));
        check("valid", 512'(valid), 512'(v));
        check("learn", 512'(learn), 512'(v && e == a_last + S && len_q));
        check("busy", 512'(busy), 512'(act || done_e == e));
        check("done", 512'(done), 512'(done_e == e));
        check("sample_idx", 512'(sample_idx), 512'(ns_q == 0 ? 0 : idx_lin % ns_q));
        check("epoch_idx", 512'(epoch_idx), 512'(ns_q == 0 ? 0 : idx_lin / ns_q));
        check("in", 512'(in), 512'(in_x));
        check("expected_out", 512'(expected_out), 512'(exp_x));
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) s_in[i] = 8'($urandom);
        for (int i = 0; i < M; i++) s_expected[i] = 8'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
        if (learn) learn_cnt++;
        if (done) done_cnt++;
        rand_data();
        start = 1'b0;
    endtask

    task automatic kick(input int ns, input int ne, input bit le);
        num_samples = SW'(ns);
        num_epochs  = EW'(ne);
        learn_en    = le;
        start       = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; learn_en = 1'b1; s_valid = 1'b0;
        num_samples = '0; num_epochs = '0;
        rand_data();
        step();
        step();
        reset = 1'b0;
        step();
        // basic run: 3 samples x 2 epochs, stream always valid
        s_valid = 1'b1;
        learn_cnt = 0; done_cnt = 0;
        kick(3, 2, 1'b1);
        repeat (30) step();
        check("basic_learns", 512'(learn_cnt), 512'(6));
        check("basic_dones", 512'(done_cnt), 512'(1));
        // zero counts
        kick(0, 2, 1'b1);
        repeat (3) step();
        kick(2, 0, 1'b1);
        repeat (3) step();
        // inference only
        learn_cnt = 0;
        kick(2, 1, 1'b0);
        repeat (12) step();
        check("infer_learns", 512'(learn_cnt), 512'(0));
        // back-pressure
        s_valid = 1'b0;
        kick(2, 1, 1'b1);
        repeat (5) step();
        s_valid = 1'b1;
        repeat (12) step();
        // abort mid-settle, then restart
        kick(3, 1, 1'b1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        kick(3, 1, 1'b1);
        repeat (16) step();
        // reset mid-learn with start held
        kick(2, 1, 1'b1);
        repeat (S + 1) step();
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        model_edge();
        #1;
        compare();
        start = 1'b0;
        reset = 1'b0;
        step();
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset       = $urandom_range(0, 299) == 0;
            abort       = $urandom_range(0, 149) == 0;
            s_valid     = $urandom_range(0, 9) < 7;
            learn_en    = $urandom_range(0, 3) != 0;
            num_samples = SW'($urandom_range(0, 4));
            num_epochs  = EW'($urandom_range(0, 3));
            start       = $urandom_range(0, 7) == 0;
            @(posedge clock);
            model_edge();
            #1;
            compare();
            rand_data();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/layer_train_sequencer.md
# layer_train_sequencer

Sequences a training run for one fully connected `neuron_learn` layer (M neurons × N inputs). It pulls (input, expected-output) samples from a valid/ready stream and presents each one to the layer. It holds `valid` for a programmable settle window, then pulses `learn` for one cycle. It repeats this over a requested number of samples and epochs. The block sits between the sample buffer/host interface and the layer instance, and drives the layer's `valid`, `learn`, `in` and `expected_out` pins.

## Interface
- `N`, 16, inputs per neuron (width of `in` arrays)
- `M`, 43, neurons in the driven layer (width of `expected_out` arrays)
- `SETTLE_CYCLES`, 2, cycles `valid` is held before `learn` fires; legal range ≥ 1
- `SW`, 16, width of sample count/index
- `EW`, 8, width of epoch count/index

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle request to begin a run; honoured only in IDLE
- `abort` in 1: return to IDLE on the next edge from any state
- `learn_en` in 1: sampled at start; 0 = inference-only run (`learn` never asserted)
- `num_samples` in SW: samples per epoch; sampled at start
- `num_epochs` in EW: epochs per run; sampled at start
- `s_valid` in 1: sample stream valid
- `s_ready` out 1: sample stream ready
- `s_in` in zero2one_t [N-1:0]: sample inputs
- `s_expected` in zero2one_t [M-1:0]: sample targets
- `valid` out 1: to layer
- `learn` out 1: to layer
- `in` out zero2one_t [N-1:0]: to layer
- `expected_out` out zero2one_t [M-1:0]: to layer
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at run completion; not raised on abort
- `sample_idx` out SW: index of the current sample within its epoch
- `epoch_idx` out EW: index of the current epoch

## Operation
- All outputs are registered (Moore); there is no combinational path from inputs to outputs.
- Reset values: state IDLE; `valid`, `learn`, `s_ready`, `busy`, `done` = 0; `in`, `expected_out` = all zero; `sample_idx`, `epoch_idx` = 0.
- States: IDLE, FETCH, SETTLE, LEARN, DONE.
- IDLE → FETCH on `start`:
  - latch `learn_en`, `num_samples`, `num_epochs`;
  - clear both indices.
  - If `num_samples`==0 or `num_epochs`==0, go to DONE instead.
- FETCH:
  - `s_ready`=1, `valid`=0, `learn`=0.
  - On `s_valid && s_ready`: capture `s_in`→`in` and `s_expected`→`expected_out`, load the settle counter, go to SETTLE.
- SETTLE:
  - `valid`=1, `learn`=0, `s_ready`=0.
  - Stay exactly SETTLE_CYCLES cycles, then go to LEARN.
- LEARN: one cycle; `valid`=1, `learn`=`learn_en` (latched copy). On exit:
  - not last sample: `sample_idx`++, go to FETCH.
  - last sample (`sample_idx`==`num_samples`-1), not last epoch: `sample_idx`=0, `epoch_idx`++, go to FETCH.
  - last sample, last epoch: go to DONE.
- DONE: `done`=1 for one cycle, all else as in IDLE except indices hold final values; go to IDLE.
- `abort`:
  - has priority over every transition;
  - next state IDLE, all outputs take reset values except the indices, which hold.
- `start` while busy is ignored. `start` and `abort` together in IDLE: abort wins, stay IDLE.
- `in` and `expected_out` are stable from sample capture until the next capture; the layer sees constant inputs across SETTLE and LEARN.
- The stream supplies samples in order; one epoch is `num_samples` consecutive accepted beats. The source replays the data per epoch.

## Timing
- `start` at edge t → `busy`=1 and `s_ready`=1 from t+1.
- Sample accepted at edge a:
  - `valid`=1 during cycles a+1 … a+SETTLE_CYCLES+1;
  - `learn` high in cycle a+SETTLE_CYCLES+1;
  - `s_ready`=1 again at a+SETTLE_CYCLES+2.
- Minimum period per sample: SETTLE_CYCLES+2 cycles.
- A final LEARN at cycle L gives `done` at L+1 and `busy`=0 at L+2.
- Stalls on `s_valid`=0 extend FETCH only; no timeout.

## Structure
- Shared package (alongside `zero2one_t`/`frac_t` in defs.svh): `train_state_t` enum.
- Optional sub-module `train_counter`: nested sample/epoch counter with last-sample/last-epoch flags.
- The settle down-counter stays inline.

## Test plan
- **Basic run:** SETTLE_CYCLES=2, num_samples=3, num_epochs=2, `s_valid` always 1.
  - Expect 6 `learn` pulses spaced 4 cycles apart.
  - `epoch_idx` goes 0→1 after the third pulse.
  - `done` pulses once, one cycle after the 6th `learn`.
- **Zero count:** num_samples=0 → `done` at start+1, no `s_ready`/`valid`; same for num_epochs=0.
- **Inference only:** `learn_en`=0, 2 samples → `valid` windows of 3 cycles each, `learn` never 1, `done` pulses.
- **Back-pressure:** `s_valid` low 5 cycles in FETCH → `valid` stays 0 and indices unchanged until the beat is accepted; captured `in` equals the beat's `s_in`.
- **Abort mid-SETTLE:** next cycle all of `valid`, `learn`, `s_ready`, `busy` = 0, no `done`; a new `start` then restarts from indices 0.
- **Reset mid-LEARN:** all outputs return to their reset values on the next edge; a `start` asserted during reset is ignored.
